hex_scan_disp: RTL and testbench



---
 rtl/hex_scan_disp_if.sv | 20 ++
 rtl/hex_scan_disp.sv | 107 ++++++++++
 tb/tb_hex_scan_disp.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hex_scan_disp_if.sv
// Byte-in / segment-out bundle for the two-digit hex scanner.
// master = producer and display observer, slave = hex_scan_disp.
interface hex_scan_disp_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       hold;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       dp_n;

  modport master (
    output in_valid, in_data, hold,
    input  seg_n, an_n, dp_n
  );

  modport slave (
    input  in_valid, in_data, hold,
    output seg_n, an_n, dp_n
  );
endinterface

// File: rtl/hex_scan_disp.sv
// Two-digit time-multiplexed common-anode hex display with blanking gaps and hold.
// Optional macro HEX_SCAN_LZ_BLANK_EN darkens digit1 when the high nibble is zero.
module hex_scan_disp #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_DIV  = 500,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  hex_scan_disp_if.slave  bus
);

  typedef enum logic [1:0] {DIG0, GAP0, DIG1, GAP1} state_t;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_DIV == 0) ? 0 : GAP_DIV - 1);
  localparam bit               HAS_GAP   = (GAP_DIV != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cap;
  logic [7:0]       shd;
  logic             shd_hold;
  logic             phase_end;

  function automatic logic [6:0] enc(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_comb begin
    phase_end = 1'b0;
    if (state == DIG0 || state == DIG1) phase_end = (cnt == SCAN_LAST);
    else                                phase_end = (cnt == GAP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DIG0;
      cnt      <= '0;
      cap      <= '0;
      shd      <= '0;
      shd_hold <= 1'b0;
    end else begin
      if (bus.in_valid && !bus.hold) cap <= bus.in_data;
      if (phase_end) begin
        cnt <= '0;
        unique case (state)
          DIG0: begin
            if (HAS_GAP) state <= GAP0;
            else         state <= DIG1;
          end
          GAP0: state <= DIG1;
          DIG1: begin
            if (HAS_GAP) begin
              state <= GAP1;
            end else begin
              // no gap: DIG1 ends the frame, so the shadow loads here
              state    <= DIG0;
              shd      <= cap;
              shd_hold <= bus.hold;
            end
          end
          default: begin
            state    <= DIG0;
            shd      <= cap;
            shd_hold <= bus.hold;
          end
        endcase
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.an_n  = 2'b11;
    bus.seg_n = 7'h7F;
    bus.dp_n  = 1'b1;
    unique case (state)
      DIG0: begin
        bus.an_n  = 2'b10;
        bus.seg_n = enc(shd[3:0]);
        bus.dp_n  = ~shd_hold;
      end
      DIG1: begin
`ifdef HEX_SCAN_LZ_BLANK_EN
        if (shd[7:4] != 4'h0) begin
          bus.an_n  = 2'b01;
          bus.seg_n = enc(shd[7:4]);
        end
`else
        bus.an_n  = 2'b01;
        bus.seg_n = enc(shd[7:4]);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hex_scan_disp.sv
// Bench for hex_scan_disp: a gapped instance (4/2) and a gapless one (4/0) share stimulus
// and are compared against a frame-position model derived from the elapsed cycle count.
module tb_hex_scan_disp;

  localparam int unsigned S  = 4;
  localparam int unsigned GA = 2;
  localparam int unsigned GB = 0;
  localparam int unsigned PA = 2 * (S + GA);
  localparam int unsigned PB = 2 * (S + GB);

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hex_scan_disp_if bus_a ();
  hex_scan_disp_if bus_b ();

  hex_scan_disp #(.SCAN_DIV(S), .GAP_DIV(GA), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  hex_scan_disp #(.SCAN_DIV(S), .GAP_DIV(GB), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state: cycles since reset release, captured byte, per-instance frame shadow
  int unsigned k;
  logic [7:0]  cap_m;
  logic [7:0]  shd_a, shd_b;
  logic        sh_a, sh_b;

  function automatic logic [9:0] exp_out(input int unsigned kk, input int unsigned g,
                                         input logic [7:0] sh, input logic hb);
    int unsigned pos;
    pos = kk % (2 * (S + g));
    if (pos < S)         return {2'b10, seg_tab[sh[3:0]], ~hb};
    if (pos < S + g)     return {2'b11, 7'h7F, 1'b1};
    if (pos < 2 * S + g) begin
`ifdef HEX_SCAN_LZ_BLANK_EN
      if (sh[7:4] == 4'h0) return {2'b11, 7'h7F, 1'b1};
`endif
      return {2'b01, seg_tab[sh[7:4]], 1'b1};
    end
    return {2'b11, 7'h7F, 1'b1};
  endfunction

  task automatic check(input string tag);
    logic [9:0] obs_a, obs_b, exp_a, exp_b;
    obs_a = {bus_a.an_n, bus_a.seg_n, bus_a.dp_n};
    obs_b = {bus_b.an_n, bus_b.seg_n, bus_b.dp_n};
    exp_a = exp_out(k, GA, shd_a, sh_a);
    exp_b = exp_out(k, GB, shd_b, sh_b);
    checks++;
    assert (obs_a === exp_a) else begin
      failures++;
      $error("FAIL %s gap2 k=%0d {an,seg,dp} got=%h want=%h", tag, k, obs_a, exp_a);
    end
    checks++;
    assert (obs_b === exp_b) else begin
      failures++;
      $error("FAIL %s gap0 k=%0d {an,seg,dp} got=%h want=%h", tag, k, obs_b, exp_b);
    end
  endtask

  task automatic model_reset();
    k = 0; cap_m = '0; shd_a = '0; shd_b = '0; sh_a = 1'b0; sh_b = 1'b0;
  endtask

  // called at a falling edge: drive, take the rising edge, update model, check
  task automatic step(input logic v, input logic [7:0] d, input logic h, input string tag);
    bus_a.in_valid = v; bus_a.in_data = d; bus_a.hold = h;
    bus_b.in_valid = v; bus_b.in_data = d; bus_b.hold = h;
    @(posedge clk);
    k++;
    if (k % PA == 0) begin shd_a = cap_m; sh_a = h; end
    if (k % PB == 0) begin shd_b = cap_m; sh_b = h; end
    if (v && !h) cap_m = d;
    #1;
    check(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n, input logic h, input string tag);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00, h, tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.hold = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.hold = 1'b0;
    #2;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release");

    idle(2 * PA, 1'b0, "idle");

    while (k % PA != S + GA + 1) step(1'b0, 8'h00, 1'b0, "to_dig1");
    step(1'b1, 8'h3A, 1'b0, "v3A");
    idle(2 * PA, 1'b0, "after3A");

    while (k % PA != PA - 2) step(1'b0, 8'h00, 1'b0, "pre_hold");
    idle(2, 1'b1, "hold_on");
    step(1'b1, 8'h55, 1'b1, "v55_held");
    idle(2 * PA, 1'b1, "held");
    step(1'b1, 8'h55, 1'b0, "v55");
    idle(2 * PA, 1'b0, "after55");

    step(1'b1, 8'hC1, 1'b0, "vC1");
    step(1'b1, 8'h7E, 1'b0, "v7E");
    idle(2 * PA, 1'b0, "after7E");

    step(1'b1, 8'h07, 1'b0, "v07");
    idle(2 * PA, 1'b0, "after07");

    for (int unsigned i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0), "rand");

    while (k % PA != S + GA + 1) step(1'b0, 8'h00, 1'b0, "to_dig1b");
    step(1'b1, 8'h9D, 1'b0, "v9D");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    @(negedge clk);
    check("rst_held");
    rst_n = 1'b1;
    idle(2 * PA + 3, 1'b0, "post_rst");
    step(1'b1, 8'hF0, 1'b0, "vF0");
    idle(2 * PA, 1'b0, "afterF0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
